uart_rx_param: RTL and testbench
================================

UART_RX_PARAM -- requirements
Module: uart_rx_param

Interface
REQ-001 Parameter DBITS, default 8: data bits per frame; legal range 5..9.
REQ-002 Parameter OVS, default 16: sample_tick pulses per bit period; even; legal range 8..32.
REQ-003 Parameter STOP_BITS, default 1: stop bits checked per frame; legal values 1 or 2.
REQ-004 clk_100MHz  input  1  system clock; all state SHALL update on its rising edge.
REQ-005 reset_n  input  1  asynchronous reset, active-low.
REQ-006 rx  input  1  serial line, idle high; asynchronous to clk_100MHz.
REQ-007 sample_tick  input  1  one-cycle enable from the baud generator, OVS pulses per bit.
REQ-008 parity_mode  input  2  00 none, 01 even, 10 odd, 11 treated as none; sampled at start-bit detection.
REQ-009 data_ready  output  1  one-cycle pulse when a frame completes.
REQ-010 data_out  output  DBITS  last received word, LSB first on the line, right-aligned.
REQ-011 frame_err  output  1  a stop bit was sampled low in the last frame.
REQ-012 parity_err  output  1  parity mismatch in the last frame.
REQ-013 break_det  output  1  last frame was a line break.
REQ-014 busy  output  1  high in every state except IDLE.

Function
REQ-015 rx SHALL pass through a 2-flop synchroniser; both flops reset to 1; all logic uses the synchronised value.
REQ-016 States: IDLE, START, DATA, PARITY, STOP, RECOVER.
REQ-017 IDLE: synchronised rx low -> START, tick counter cleared, parity_mode latched.
REQ-018 START: on the tick where counter = OVS/2-1, rx high -> IDLE (false start, no pulse, no error); rx low -> DATA, counters cleared.
REQ-019 DATA: on every OVS-th tick (counter = OVS-1), shift rx into the data shift register; after DBITS bits go to PARITY if the latched mode is 01/10, else to STOP.
REQ-020 PARITY: sample rx at counter = OVS-1; mismatch against even/odd parity of the data bits is recorded as a parity error; then go to STOP.
REQ-021 STOP: sample rx at counter = k*OVS-1 for k = 1..STOP_BITS; any low sample is recorded as a frame error; the frame ends at counter = STOP_BITS*OVS-1.
REQ-022 At frame end: data_ready pulses the next cycle; data_out, frame_err, parity_err and break_det update in that same cycle and hold until the next data_ready.
REQ-023 Break: all data bits 0, parity bit (if any) 0 and a frame error -> break_det=1 and frame_err=1.
REQ-024 After the frame ends with rx high -> IDLE; with rx low -> RECOVER. RECOVER -> IDLE on the first synchronised rx high, so a break yields exactly one frame.
REQ-025 The counter SHALL be $clog2(STOP_BITS*OVS)+1 bits wide and advance only on sample_tick; no state advances without a tick except IDLE and RECOVER exit.
REQ-026 No input is ever dropped mid-frame; the previous data_out is overwritten without back-pressure (the consumer is the FIFO).

Reset
REQ-027 reset_n low SHALL immediately force IDLE, all counters 0, data_out 0, data_ready 0, frame_err 0, parity_err 0, break_det 0, busy 0, regardless of frame progress.
REQ-028 After reset_n deasserts, the first falling edge of rx SHALL start a frame normally.

Configuration
REQ-029 Macro UART_RX_PARITY_EN defined: PARITY state and parity_err logic SHALL be present as in REQ-019/020.
REQ-030 Macro UART_RX_PARITY_EN undefined: PARITY state absent, parity_mode ignored, parity_err tied 0, and DATA always goes directly to STOP.

Verification (DBITS=8, OVS=16, STOP_BITS=1, sample_tick every 4 clocks, UART_RX_PARITY_EN defined)
REQ-031 Frame 0x55, mode none -> one data_ready, data_out=0x55, all error flags 0, busy low after the pulse.
REQ-032 rx low for 4 ticks, then high -> no data_ready, busy returns low after tick 7.
REQ-033 Frame 0xA3, mode even, parity bit sent 1 (wrong) -> data_out=0xA3, parity_err=1, frame_err=0.
REQ-034 Frame 0x0F with the stop bit driven low -> data_out=0x0F, frame_err=1, break_det=0.
REQ-035 rx held low for 20 bit times, then high, then frame 0x3C -> first pulse data_out=0x00, frame_err=1, break_det=1; no further pulse until rx high; then data_out=0x3C with no errors.
REQ-036 reset_n pulsed low during bit 4 of a frame -> all outputs 0 within the reset window; next frame 0xC9 received correctly.

Source files
------------

// File: rtl/uart_rx_param_if.sv
// rtl/uart_rx_param_if.sv - serial line, tick and received-word signals of the UART receiver
interface uart_rx_param_if #(
  parameter int DBITS = 8
);
  logic             rx;
  logic             sample_tick;
  logic [1:0]       parity_mode;
  logic [DBITS-1:0] data_out;
  logic             data_ready;
  logic             frame_err;
  logic             parity_err;
  logic             break_det;
  logic             busy;

  modport master (
    input  rx, sample_tick, parity_mode,
    output data_out, data_ready, frame_err, parity_err, break_det, busy
  );

  modport slave (
    output rx, sample_tick, parity_mode,
    input  data_out, data_ready, frame_err, parity_err, break_det, busy
  );
endinterface

// File: rtl/uart_rx_param.sv
// rtl/uart_rx_param.sv - oversampling UART receiver with frame/parity/break reporting
// Parity checking is built only when UART_RX_PARITY_EN is defined.
module uart_rx_param #(
  parameter int DBITS     = 8,
  parameter int OVS       = 16,
  parameter int STOP_BITS = 1
) (
  input logic             clk_100MHz,
  input logic             reset_n,
  uart_rx_param_if.master bus
);
  localparam int CW = $clog2(STOP_BITS * OVS) + 1;
  localparam int BW = $clog2(DBITS + 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(OVS / 2 - 1);
  localparam logic [CW-1:0] CNT_BIT  = CW'(OVS - 1);
  localparam logic [CW-1:0] CNT_BIT2 = CW'(2 * OVS - 1);
  localparam logic [CW-1:0] CNT_END  = CW'(STOP_BITS * OVS - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DBITS - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_START   = 3'd1,
    S_DATA    = 3'd2,
`ifdef UART_RX_PARITY_EN
    S_PARITY  = 3'd3,
`endif
    S_STOP    = 3'd4,
    S_RECOVER = 3'd5
  } state_e;

  state_e           state_q, state_d;
  logic             rx_meta_q, rx_meta_d;
  logic             rx_sync_q, rx_sync_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic [DBITS-1:0] shreg_q, shreg_d;
  logic             stop_err_q, stop_err_d;
  logic [DBITS-1:0] data_out_q, data_out_d;
  logic             frame_err_q, frame_err_d;
  logic             break_det_q, break_det_d;
  logic             data_ready_q, data_ready_d;
  logic             fe_now;
  logic             stop_pt;
`ifdef UART_RX_PARITY_EN
  logic [1:0]       pmode_q, pmode_d;
  logic             par_bit_q, par_bit_d;
  logic             par_err_q, par_err_d;
  logic             parity_err_q, parity_err_d;
  logic             par_used;
  logic             par_exp;

  assign par_used = (pmode_q == 2'b01) || (pmode_q == 2'b10);
  // Even mode expects XOR of the data; odd mode (10) expects its inverse.
  assign par_exp  = (^shreg_q) ^ pmode_q[1];
`else
  logic             unused_pmode;
  assign unused_pmode = ^bus.parity_mode;
`endif

  assign stop_pt = (cnt_q == CNT_BIT) || ((STOP_BITS == 2) && (cnt_q == CNT_BIT2));

  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      rx_meta_q    <= 1'b1;
      rx_sync_q    <= 1'b1;
      cnt_q        <= '0;
      bit_q        <= '0;
      shreg_q      <= '0;
      stop_err_q   <= 1'b0;
      data_out_q   <= '0;
      frame_err_q  <= 1'b0;
      break_det_q  <= 1'b0;
      data_ready_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      pmode_q      <= 2'b00;
      par_bit_q    <= 1'b0;
      par_err_q    <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      rx_meta_q    <= rx_meta_d;
      rx_sync_q    <= rx_sync_d;
      cnt_q        <= cnt_d;
      bit_q        <= bit_d;
      shreg_q      <= shreg_d;
      stop_err_q   <= stop_err_d;
      data_out_q   <= data_out_d;
      frame_err_q  <= frame_err_d;
      break_det_q  <= break_det_d;
      data_ready_q <= data_ready_d;
`ifdef UART_RX_PARITY_EN
      pmode_q      <= pmode_d;
      par_bit_q    <= par_bit_d;
      par_err_q    <= par_err_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  always_comb begin
    rx_meta_d    = bus.rx;
    rx_sync_d    = rx_meta_q;
    state_d      = state_q;
    cnt_d        = cnt_q;
    bit_d        = bit_q;
    shreg_d      = shreg_q;
    stop_err_d   = stop_err_q;
    data_out_d   = data_out_q;
    frame_err_d  = frame_err_q;
    break_det_d  = break_det_q;
    data_ready_d = 1'b0;
    fe_now       = 1'b0;
`ifdef UART_RX_PARITY_EN
    pmode_d      = pmode_q;
    par_bit_d    = par_bit_q;
    par_err_d    = par_err_q;
    parity_err_d = parity_err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (!rx_sync_q) begin
          state_d    = S_START;
          cnt_d      = '0;
          bit_d      = '0;
          stop_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
          pmode_d    = bus.parity_mode;
          par_bit_d  = 1'b0;
          par_err_d  = 1'b0;
`endif
        end
      end
      S_START: begin
        if (bus.sample_tick) begin
          if (cnt_q == CNT_HALF) begin
            cnt_d   = '0;
            state_d = rx_sync_q ? S_IDLE : S_DATA;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      S_DATA: begin
        if (bus.sample_tick) begin
          if (cnt_q == CNT_BIT) begin
            cnt_d   = '0;
            shreg_d = {rx_sync_q, shreg_q[DBITS-1:1]};
            bit_d   = bit_q + BW'(1);
            if (bit_q == BIT_LAST) begin
              bit_d = '0;
`ifdef UART_RX_PARITY_EN
              state_d = par_used ? S_PARITY : S_STOP;
`else
              state_d = S_STOP;
`endif
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (bus.sample_tick) begin
          if (cnt_q == CNT_BIT) begin
            cnt_d     = '0;
            par_bit_d = rx_sync_q;
            par_err_d = (rx_sync_q != par_exp);
            state_d   = S_STOP;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
`endif
      S_STOP: begin
        if (bus.sample_tick) begin
          if (stop_pt && !rx_sync_q) begin
            stop_err_d = 1'b1;
          end
          if (cnt_q == CNT_END) begin
            // The last stop sample coincides with frame end, so fold it in here.
            fe_now       = stop_err_q | ~rx_sync_q;
            cnt_d        = '0;
            data_ready_d = 1'b1;
            data_out_d   = shreg_q;
            frame_err_d  = fe_now;
`ifdef UART_RX_PARITY_EN
            parity_err_d = par_err_q;
            break_det_d  = fe_now && (shreg_q == '0) && !(par_used && par_bit_q);
`else
            break_det_d  = fe_now && (shreg_q == '0);
`endif
            state_d      = rx_sync_q ? S_IDLE : S_RECOVER;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      S_RECOVER: begin
        if (rx_sync_q) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.data_out   = data_out_q;
    bus.data_ready = data_ready_q;
    bus.frame_err  = frame_err_q;
    bus.break_det  = break_det_q;
    bus.busy       = (state_q != S_IDLE);
`ifdef UART_RX_PARITY_EN
    bus.parity_err = parity_err_q;
`else
    bus.parity_err = 1'b0;
`endif
  end
endmodule

// File: tb/tb_uart_rx_param.sv
// tb/tb_uart_rx_param.sv - directed self-checking bench for uart_rx_param (8N1/8E1/8O1, OVS 16)
module tb_uart_rx_param;
  localparam int BITCLK = 64;
`ifdef UART_RX_PARITY_EN
  localparam logic PE_A3 = 1'b1;
`else
  localparam logic PE_A3 = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n;
  int   errors = 0;
  int   checks = 0;
  int   pulses = 0;

  uart_rx_param_if #(.DBITS(8)) bus ();

  uart_rx_param #(.DBITS(8), .OVS(16), .STOP_BITS(1)) dut (
    .clk_100MHz (clk),
    .reset_n    (reset_n),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.data_ready === 1'b1) pulses++;
  end

  initial begin
    bus.sample_tick = 1'b0;
    forever begin
      for (int i = 0; i < 4; i++) begin
        @(posedge clk);
        #1;
        bus.sample_tick = (i == 3);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_word(input string tag, input logic [7:0] d, input logic fe,
                            input logic pe, input logic bd);
    check({tag, "_data"}, 32'(bus.data_out), 32'(d));
    check({tag, "_frame_err"}, 32'(bus.frame_err), 32'(fe));
    check({tag, "_parity_err"}, 32'(bus.parity_err), 32'(pe));
    check({tag, "_break"}, 32'(bus.break_det), 32'(bd));
  endtask

  task automatic line_bits(input logic v, input int n);
    bus.rx = v;
    repeat (n * BITCLK) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par_slot, input logic par_bit,
                            input logic stop_bit);
    line_bits(1'b0, 1);
    for (int i = 0; i < 8; i++) line_bits(d[i], 1);
    if (par_slot) line_bits(par_bit, 1);
    line_bits(stop_bit, 1);
    line_bits(1'b1, 1);
  endtask

  initial begin
    reset_n         = 1'b0;
    bus.rx          = 1'b1;
    bus.parity_mode = 2'b00;
    repeat (5) @(posedge clk);
    #1;
    check_word("rst", 8'h00, 1'b0, 1'b0, 1'b0);
    check("rst_ready", 32'(bus.data_ready), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    reset_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;

    send_frame(8'h55, 1'b0, 1'b0, 1'b1);
    line_bits(1'b1, 1);
    check("f55_pulses", 32'(pulses), 32'd1);
    check_word("f55", 8'h55, 1'b0, 1'b0, 1'b0);
    check("f55_busy", 32'(bus.busy), 32'd0);

    bus.rx = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("false_start_busy_hi", 32'(bus.busy), 32'd1);
    repeat (6) @(posedge clk);
    #1;
    line_bits(1'b1, 2);
    check("false_start_pulses", 32'(pulses), 32'd1);
    check("false_start_busy_lo", 32'(bus.busy), 32'd0);

    bus.parity_mode = 2'b01;
    send_frame(8'hA3, 1'b1, 1'b1, 1'b1);
    line_bits(1'b1, 1);
    check("fa3_pulses", 32'(pulses), 32'd2);
    check_word("fa3", 8'hA3, 1'b0, PE_A3, 1'b0);

    bus.parity_mode = 2'b00;
    send_frame(8'h0F, 1'b0, 1'b0, 1'b0);
    line_bits(1'b1, 1);
    check("f0f_pulses", 32'(pulses), 32'd3);
    check_word("f0f", 8'h0F, 1'b1, 1'b0, 1'b0);
    check("f0f_busy", 32'(bus.busy), 32'd0);

    line_bits(1'b0, 20);
    check("brk_pulses", 32'(pulses), 32'd4);
    check_word("brk", 8'h00, 1'b1, 1'b0, 1'b1);
    check("brk_busy_recover", 32'(bus.busy), 32'd1);
    line_bits(1'b1, 2);
    check("brk_idle_busy", 32'(bus.busy), 32'd0);
    send_frame(8'h3C, 1'b0, 1'b0, 1'b1);
    line_bits(1'b1, 1);
    check("f3c_pulses", 32'(pulses), 32'd5);
    check_word("f3c", 8'h3C, 1'b0, 1'b0, 1'b0);

    bus.parity_mode = 2'b10;
    line_bits(1'b0, 1);
    for (int i = 0; i < 4; i++) line_bits(1'b1, 1);
    bus.rx = 1'b0;
    repeat (BITCLK / 2) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check_word("mid_rst", 8'h00, 1'b0, 1'b0, 1'b0);
    check("mid_rst_ready", 32'(bus.data_ready), 32'd0);
    check("mid_rst_busy", 32'(bus.busy), 32'd0);
    bus.rx = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    reset_n = 1'b1;
    line_bits(1'b1, 2);
    check("mid_rst_pulses", 32'(pulses), 32'd5);
    send_frame(8'hC9, 1'b1, 1'b1, 1'b1);
    line_bits(1'b1, 1);
    check("fc9_pulses", 32'(pulses), 32'd6);
    check_word("fc9", 8'hC9, 1'b0, 1'b0, 1'b0);
    check("fc9_busy", 32'(bus.busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
